id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register sitting directly downstream of the register file. It captures the decoded instruction and both register-file read operands.
- Closes the write-then-read gap: a same-cycle writeback is not yet visible on the asynchronous read ports, so the block bypasses the writeback value into the captured operand.
- Detects load-use hazards and inserts bubbles.
- Honours global stall and flush from the hazard/branch logic.

Parameters:
CTRL_W, 12, width of the opaque decoded control bundle carried to EX.
MEMRD_BIT, 0, bit index within the control bundle that marks a load (memory read).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
stall  in  1  hold EX contents (back-pressure from a downstream stage).
flush  in  1  kill the instruction entering EX (taken branch/jump).
id_valid  in  1  ID holds a real instruction.
id_pc  in  32  PC of the ID instruction.
id_rs1  in  5  source register 1 index, also drives the register file rs1 port.
id_rs2  in  5  source register 2 index, also drives the register file rs2 port.
id_rd  in  5  destination index.
id_rd1  in  32  register file read data 1.
id_rd2  in  32  register file read data 2.
id_imm  in  32  sign-extended immediate.
id_ctrl  in  CTRL_W  decoded control.
wb_we  in  1  writeback enable; same signal as the register file write enable.
wb_rd  in  5  writeback destination.
wb_wd  in  32  writeback data.
hazard_stall  out  1  combinational; the IF/ID stages must hold when this is 1.
ex_valid  out  1  EX holds a real instruction.
ex_pc  out  32  captured PC.
ex_rs1  out  5  captured source index 1.
ex_rs2  out  5  captured source index 2.
ex_rd  out  5  captured destination index.
ex_op1  out  32  captured operand 1.
ex_op2  out  32  captured operand 2.
ex_imm  out  32  captured immediate.
ex_ctrl  out  CTRL_W  captured control.

Behaviour:
- All ex_* outputs are registered and update on the rising edge of clk.
- Reset: rst=1 at an edge sets every ex_* output to 0, including ex_valid=0. Reset has top priority.
- hazard_stall = id_valid & ex_valid & ex_ctrl[MEMRD_BIT] & (ex_rd!=0) & ((ex_rd==id_rs1) | (ex_rd==id_rs2)) & ~stall & ~flush.
- Per-edge priority, highest first:
  1. rst.
  2. flush: bubble (ex_valid=0, ex_ctrl=0, other fields 0).
  3. stall: hold all fields; apply the held-operand update below.
  4. hazard_stall: bubble, same encoding as flush.
  5. load: capture all id_* fields; ex_valid=id_valid.
- A bubble always forces ex_ctrl to all-zero. ex_valid=0 on its own is insufficient.
- Load bypass:
  - ex_op1 = (wb_we & wb_rd!=0 & wb_rd==id_rs1) ? wb_wd : id_rd1. ex_op2 is formed the same way from id_rs2 and id_rd2.
  - An index of x0 never bypasses. An x0 source captures id_rd1/id_rd2, which the register file already forces to 0.
- Held-operand update during stall: if wb_we & wb_rd!=0 & wb_rd==ex_rs1, then ex_op1<=wb_wd; ex_op2 likewise with ex_rs2. Prevents held operands going stale while older instructions retire.
- Simultaneous events:
  - flush and stall together → flush wins.
  - stall and a load-use condition together → hold only; hazard_stall=0.
  - rst during stall/flush → reset wins.
- Latency: exactly one cycle from ID to EX. There is no internal state besides the ex_* registers.

Decomposition:
- Shared package holds:
  - REG_IDX_W=5, XLEN=32, REG_ZERO=5'd0.
  - The control-bundle bit-index constants (MEMRD_BIT, plus the remaining control-bit indices), shared with the decoder and the EX stage.
- One natural sub-module, wb_bypass_mux. Inputs: source index, read data, wb_we, wb_rd, wb_wd; output: selected operand. It is instantiated four times: load op1, load op2, held op1, held op2.
- Hazard compare and the pipeline register stay in the top module.

Test Plan:
1. Reset → all ex_* outputs 0, hazard_stall=0. Release rst, then load id_pc=0x100, id_rs1=3, id_rd1=0x11 with no writeback → next cycle ex_pc=0x100, ex_op1=0x11, ex_valid=1.
2. Bypass: id_rs1=5, id_rd1=0xAAAA, wb_we=1, wb_rd=5, wb_wd=0x1234 → ex_op1=0x1234. Repeat with wb_rd=0, id_rs1=0, id_rd1=0 → ex_op1=0.
3. Load-use: EX holds a load with ex_rd=7; ID has id_rs2=7 → hazard_stall=1 that cycle; next edge ex_valid=0, ex_ctrl=0. The following cycle hazard_stall=0 and the instruction loads normally.
4. Flush and stall asserted together with a valid ID instruction → next cycle ex_valid=0, ex_ctrl=0.
5. Stall for 3 cycles with ex_rs1=9 held; in cycle 2 apply wb_we=1, wb_rd=9, wb_wd=0xBEEF → ex_op1 becomes 0xBEEF; all other fields remain unchanged.
6. Assert rst mid-stall while EX holds a valid load → next edge all outputs 0, hazard_stall=0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared widths, register-index constants and control-bundle
//               bit positions for the ID/EX boundary.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  // Control bundle layout, shared with the decoder and the EX stage
  localparam int CTRL_W_DEFAULT   = 12;
  localparam int CTRL_MEMRD_BIT   = 0;
  localparam int CTRL_MEMWR_BIT   = 1;
  localparam int CTRL_REGWR_BIT   = 2;
  localparam int CTRL_MEM2REG_BIT = 3;
  localparam int CTRL_BRANCH_BIT  = 4;
  localparam int CTRL_JUMP_BIT    = 5;
  localparam int CTRL_ALUSRC_BIT  = 6;
  localparam int CTRL_ALUOP_LSB   = 7;
  localparam int CTRL_ALUOP_W     = 4;
  localparam int CTRL_USEPC_BIT   = 11;

  function automatic logic wb_hit(
    input logic                 we,
    input logic [REG_IDX_W-1:0] wb_rd,
    input logic [REG_IDX_W-1:0] src
  );
    return we && (wb_rd != REG_ZERO) && (wb_rd == src);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_bypass_mux.sv
// ============================================================================
// Module      : wb_bypass_mux
// Description : Selects the writeback value over stale read data when the
//               writeback targets the given (non-x0) source register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_bypass_mux
  import id_ex_stage_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src_i,
  input  logic [XLEN-1:0]      rdata_i,
  input  logic                 wb_we_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]      wb_wd_i,
  output logic [XLEN-1:0]      op_o
);

  assign op_o = wb_hit(wb_we_i, wb_rd_i, src_i) ? wb_wd_i : rdata_i;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with writeback bypass, load-use
//               bubble insertion, stall hold and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int CTRL_W    = CTRL_W_DEFAULT,
  parameter int MEMRD_BIT = CTRL_MEMRD_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic [XLEN-1:0]      id_rd1,
  input  logic [XLEN-1:0]      id_rd2,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_wd,
  output logic                 hazard_stall,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [XLEN-1:0]      ex_op1,
  output logic [XLEN-1:0]      ex_op2,
  output logic [XLEN-1:0]      ex_imm,
  output logic [CTRL_W-1:0]    ex_ctrl
);

  logic                 valid_q, valid_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic [REG_IDX_W-1:0] rs1_q, rs1_d;
  logic [REG_IDX_W-1:0] rs2_q, rs2_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]      op1_q, op1_d;
  logic [XLEN-1:0]      op2_q, op2_d;
  logic [XLEN-1:0]      imm_q, imm_d;
  logic [CTRL_W-1:0]    ctrl_q, ctrl_d;

  logic [XLEN-1:0] load_op1, load_op2;
  logic [XLEN-1:0] held_op1, held_op2;
  logic            src_match;

  // Same-cycle writeback is invisible on the async read ports, so bypass it
  wb_bypass_mux u_load_op1 (
    .src_i(id_rs1), .rdata_i(id_rd1),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_wd_i(wb_wd),
    .op_o(load_op1)
  );

  wb_bypass_mux u_load_op2 (
    .src_i(id_rs2), .rdata_i(id_rd2),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_wd_i(wb_wd),
    .op_o(load_op2)
  );

  // Held operands keep tracking retiring writes while EX is stalled
  wb_bypass_mux u_held_op1 (
    .src_i(rs1_q), .rdata_i(op1_q),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_wd_i(wb_wd),
    .op_o(held_op1)
  );

  wb_bypass_mux u_held_op2 (
    .src_i(rs2_q), .rdata_i(op2_q),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_wd_i(wb_wd),
    .op_o(held_op2)
  );

  assign src_match    = (rd_q == id_rs1) || (rd_q == id_rs2);
  assign hazard_stall = id_valid & valid_q & ctrl_q[MEMRD_BIT] & (rd_q != REG_ZERO)
                      & src_match & ~stall & ~flush;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    if (flush || (!stall && hazard_stall)) begin
      // Bubble: control must be cleared too, not only the valid bit
      valid_d = 1'b0;
      pc_d    = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      op1_d   = '0;
      op2_d   = '0;
      imm_d   = '0;
      ctrl_d  = '0;
    end else if (stall) begin
      op1_d = held_op1;
      op2_d = held_op2;
    end else begin
      valid_d = id_valid;
      pc_d    = id_pc;
      rs1_d   = id_rs1;
      rs2_d   = id_rs2;
      rd_d    = id_rd;
      op1_d   = load_op1;
      op2_d   = load_op2;
      imm_d   = id_imm;
      ctrl_d  = id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ex_valid = valid_q;
  assign ex_pc    = pc_q;
  assign ex_rs1   = rs1_q;
  assign ex_rs2   = rs2_q;
  assign ex_rd    = rd_q;
  assign ex_op1   = op1_q;
  assign ex_op2   = op2_q;
  assign ex_imm   = imm_q;
  assign ex_ctrl  = ctrl_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Scoreboard bench for id_ex_stage with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  typedef struct {
    logic        hz;
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [11:0] ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid, wb_we;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm, wb_wd;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic [11:0] id_ctrl;
  logic        hazard_stall, ex_valid;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [11:0] ex_ctrl;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(12), .MEMRD_BIT(0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
  );

  function automatic exp_t mk(input logic hz, input logic v, input logic [31:0] pc,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [31:0] imm, input logic [11:0] ctrl);
    exp_t e;
    e.hz = hz; e.v = v; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.op1 = op1; e.op2 = op2; e.imm = imm; e.ctrl = ctrl;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_ctl(input logic r, input logic s, input logic f);
    rst = r; stall = s; flush = f;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic [31:0] imm, input logic [11:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_ctrl = ctrl;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] wd);
    wb_we = we; wb_rd = rd; wb_wd = wd;
  endtask

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: hazard_stall is checked mid-cycle, EX fields just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, e.hz});
        @(posedge clk);
        #1;
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_rs1", {27'd0, ex_rs1}, {27'd0, e.rs1});
        chk("ex_rs2", {27'd0, ex_rs2}, {27'd0, e.rs2});
        chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
        chk("ex_op1", ex_op1, e.op1);
        chk("ex_op2", ex_op2, e.op2);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_ctrl", {20'd0, ex_ctrl}, {20'd0, e.ctrl});
      end
    end
  end

  initial begin
    set_ctl(1, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    @(negedge clk);

    // Reset
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000));

    // Plain load, no writeback
    set_ctl(0, 0, 0);
    set_id(1, 32'h100, 3, 4, 2, 32'h11, 32'h22, 32'h5, 12'h004);
    step(mk(0, 1, 32'h100, 3, 4, 2, 32'h11, 32'h22, 32'h5, 12'h004));

    // Writeback bypass into op1
    set_id(1, 32'h104, 5, 6, 8, 32'hAAAA, 32'hBBBB, 0, 12'h004);
    set_wb(1, 5, 32'h1234);
    step(mk(0, 1, 32'h104, 5, 6, 8, 32'h1234, 32'hBBBB, 0, 12'h004));

    // x0 never bypasses
    set_id(1, 32'h108, 0, 6, 9, 0, 32'h66, 0, 12'h004);
    set_wb(1, 0, 32'h1234);
    step(mk(0, 1, 32'h108, 0, 6, 9, 0, 32'h66, 0, 12'h004));

    // Bypass into op2
    set_id(1, 32'h10C, 1, 6, 9, 32'h10, 32'h66, 0, 12'h004);
    set_wb(1, 6, 32'h5555);
    step(mk(0, 1, 32'h10C, 1, 6, 9, 32'h10, 32'h5555, 0, 12'h004));

    // Load into EX (wb_we=0 with matching index must not bypass)
    set_id(1, 32'h110, 1, 2, 7, 32'h10, 32'h20, 0, 12'h005);
    set_wb(0, 1, 32'hFFFF);
    step(mk(0, 1, 32'h110, 1, 2, 7, 32'h10, 32'h20, 0, 12'h005));

    // Load-use on rs2: bubble, then normal load
    set_id(1, 32'h114, 3, 7, 10, 32'h30, 32'h70, 32'h8, 12'h004);
    set_wb(0, 0, 0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000));
    step(mk(0, 1, 32'h114, 3, 7, 10, 32'h30, 32'h70, 32'h8, 12'h004));

    // Load targeting x0 never raises a hazard
    set_id(1, 32'h118, 4, 5, 0, 32'h40, 32'h50, 0, 12'h001);
    step(mk(0, 1, 32'h118, 4, 5, 0, 32'h40, 32'h50, 0, 12'h001));
    set_id(1, 32'h11C, 0, 0, 1, 0, 0, 0, 12'h004);
    step(mk(0, 1, 32'h11C, 0, 0, 1, 0, 0, 0, 12'h004));

    // Flush and stall together
    set_ctl(0, 1, 1);
    set_id(1, 32'h120, 1, 0, 3, 32'h1, 0, 0, 12'h004);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000));

    // Load into EX, then stall three cycles with retiring writes
    set_ctl(0, 0, 0);
    set_id(1, 32'h130, 9, 10, 11, 32'h99, 32'hA0, 32'h33, 12'h005);
    step(mk(0, 1, 32'h130, 9, 10, 11, 32'h99, 32'hA0, 32'h33, 12'h005));
    set_ctl(0, 1, 0);
    set_id(1, 32'h134, 11, 0, 12, 32'h1, 32'h2, 0, 12'h004);
    step(mk(0, 1, 32'h130, 9, 10, 11, 32'h99, 32'hA0, 32'h33, 12'h005));
    set_wb(1, 9, 32'hBEEF);
    step(mk(0, 1, 32'h130, 9, 10, 11, 32'hBEEF, 32'hA0, 32'h33, 12'h005));
    set_wb(1, 10, 32'hCAFE);
    step(mk(0, 1, 32'h130, 9, 10, 11, 32'hBEEF, 32'hCAFE, 32'h33, 12'h005));

    // Reset mid-stall while EX holds a valid load
    set_ctl(1, 1, 0);
    set_wb(0, 0, 0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000));
    set_ctl(0, 0, 0);
    step(mk(0, 1, 32'h134, 11, 0, 12, 32'h1, 32'h2, 0, 12'h004));

    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
